// File: rtl/seg7_pkg.sv
// Shared definitions for the display datapath (binary-to-BCD converter and
// 7-segment scan driver).
//   bcd_digit_t : one packed BCD nibble
//   b2b_state_t : control states of the iterative converter
//   NUM_DIGITS  : number of display digits
//   pow10()     : integer power of ten, used for compile-time saturation bounds
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready handshake bundle for the binary-to-BCD converter.
//   in_valid/in_ready/in_bin            : binary input channel
//   out_valid/out_ready/out_bcd/out_ovf : BCD result channel
// slave modport is the converter side, master is the producer/consumer side.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_ovf;

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf
    );

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf
    );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble per-digit correction: a nibble of 5 or more gets +3 so that
// the following left shift carries into the next decimal digit.
//   d_i : BCD nibble before correction
//   q_o : corrected nibble
module bcd_add3
    import seg7_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t q_o
);

    always_comb begin
        q_o = (d_i >= 4'd5) ? bcd_digit_t'(d_i + 4'd3) : d_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : handshake bundle (slave side)
//         in_valid/in_ready/in_bin   - value to convert
//         out_valid/out_ready        - result handshake
//         out_bcd                    - packed BCD, digit 0 in [3:0]
//         out_ovf                    - input exceeded 10^DIGITS-1, out_bcd saturated
// A value accepted at edge k is presented after edge k+BIN_W. The result
// registers keep their value after the handshake until the next conversion
// finishes, so a display can keep showing it.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = NUM_DIGITS
) (
    input  logic        clk,
    input  logic        rst,
    bin2bcd_seq_if.slave bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam longint unsigned BIN_MAX = (64'd1 << BIN_W) - 1;
    // When every BIN_W-bit input fits in DIGITS digits the compare folds away.
    localparam bit OVF_POSSIBLE = (MAX_VAL < BIN_MAX);

    b2b_state_t         state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               out_ovf_q, out_ovf_d;

    logic [SR_W-1:0]    sr_corr;
    logic [SR_W-1:0]    sr_shift;
    logic [BCD_W-1:0]   bcd_sat;
    logic               in_ovf;
    logic               unused_msb;

    // Correct every BCD nibble in parallel, binary part passes untouched.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .d_i (sr_q[BIN_W + 4*gi +: 4]),
                .q_o (sr_corr[BIN_W + 4*gi +: 4])
            );
        end
    endgenerate

    assign sr_corr[BIN_W-1:0] = sr_q[BIN_W-1:0];
    // The bit shifted out is only non-zero on an overflowing input, whose
    // result is replaced by the saturated value anyway.
    assign unused_msb = sr_corr[SR_W-1];
    assign sr_shift   = {sr_corr[SR_W-2:0], 1'b0};
    assign bcd_sat    = {DIGITS{BCD_NINE}};

    always_comb begin
        in_ovf = OVF_POSSIBLE &&
                 ({{(64-BIN_W){1'b0}}, bus.in_bin} > MAX_VAL);
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_bcd_d = out_bcd_q;
        out_ovf_d = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_d    = {{BCD_W{1'b0}}, bus.in_bin};
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = in_ovf;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    out_bcd_d = ovf_q ? bcd_sat : sr_shift[SR_W-1 -: BCD_W];
                    out_ovf_d = ovf_q;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_bcd_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_bcd_q <= out_bcd_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   n_in;
    int   n_out;
    int   acc_cyc;
    bit   rand_ready;

    logic [16:0] sb[$];

    bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [16:0] model(input int v);
        logic [16:0] r;
        int x;
        if (v > 9999) return {1'b1, 16'h9999};
        r = '0;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Issue one value; called at posedge+1, returns at posedge+1 after the accept edge.
    task automatic send(input int v, input logic [15:0] eb, input logic eo);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            bus.in_valid = 1'b1;
            bus.in_bin   = 14'(v);
            @(posedge clk);
            sb.push_back({eo, eb});
            n_in++;
            #1;
            acc_cyc      = cyc;
            bus.in_valid = 1'b0;
            $display("send in_bin=%0d expect bcd=%h ovf=%0d at cycle %0d", v, eb, eo, acc_cyc);
        end
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus.out_valid;
        if (!ok) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    // Scoreboard monitor: one pop per completed output handshake.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual bcd=%h ovf=%0d required none", bus.out_bcd, bus.out_ovf);
                end else begin
                    e = sb.pop_front();
                    $display("result bcd=%h ovf=%0d expected bcd=%h ovf=%0d", bus.out_bcd, bus.out_ovf, e[15:0], e[16]);
                    chk("result_bcd", 32'(bus.out_bcd), 32'(e[15:0]));
                    chk("result_ovf", 32'(bus.out_ovf), 32'(e[16]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int a1;
        int v;
        logic [16:0] m;
        cyc = 0; checks = 0; errors = 0; n_in = 0; n_out = 0; rand_ready = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bin = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_bcd", 32'(bus.out_bcd), 32'd0);
        chk("reset_out_ovf", 32'(bus.out_ovf), 32'd0);

        // 1234: in_ready drop and 14-cycle latency
        bus.out_ready = 1'b1;
        send(1234, 16'h1234, 1'b0);
        chk("in_ready_drop", 32'(bus.in_ready), 32'd0);
        wait_valid(ok);
        if (ok) chk("latency", 32'(cyc - acc_cyc), 32'd14);
        @(posedge clk); #1;

        // back-to-back 0 and 9999
        send(0, 16'h0000, 1'b0);
        a1 = acc_cyc;
        send(9999, 16'h9999, 1'b0);
        chk("issue_interval_ge15", 32'(((acc_cyc - a1) >= 15) ? 1 : 0), 32'd1);

        // overflow saturation
        send(10000, 16'h9999, 1'b1);
        send(16383, 16'h9999, 1'b1);
        wait_valid(ok);
        @(posedge clk); #1;

        // stall with ignored input pulses
        bus.out_ready = 1'b0;
        send(42, 16'h0042, 1'b0);
        wait_valid(ok);
        for (int i = 0; i < 20; i++) begin
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_out_bcd", 32'(bus.out_bcd), 32'h0042);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = i[0];
            bus.in_bin   = 14'd777;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("retained_out_bcd", 32'(bus.out_bcd), 32'h0042);

        // reset during SHIFT
        send(5678, 16'h5678, 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        n_in--;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_bcd", 32'(bus.out_bcd), 32'd0);
        chk("abort_out_ovf", 32'(bus.out_ovf), 32'd0);
        send(5678, 16'h5678, 1'b0);

        // random sweep with consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            v = (i == 0) ? 9999 : (i == 1) ? 10000 : int'($urandom_range(0, 16383));
            m = model(v);
            send(v, m[15:0], m[16]);
        end
        for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("handshake_count", 32'(n_out), 32'(n_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
